// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line idle level and
// the parity helper used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Even parity: XOR of all data bits; narrower words are zero-extended.
    function automatic logic uart_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL selects the level both flops take while rst is high.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit validation, centre sampling, stop check, valid/ready out.
// Optional even-parity bit after the data when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]  LAST = 4'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t       state, state_n;
    logic [15:0]          cnt, cnt_n;
    logic [3:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n;
    logic                 fe_n, oe_n;
    logic                 cnt_zero;

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_n;
    logic pe_q, pe_n;
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

    uart_sync2 #(
        .RST_VAL(UART_IDLE_LEVEL)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    assign cnt_zero = (cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q      <= 1'b0;
            pe_q        <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            rx_data     <= data_n;
            rx_valid    <= valid_n;
            frame_err   <= fe_n;
            overrun_err <= oe_n;
`ifdef UART_RX_PARITY_EN
            perr_q      <= perr_n;
            pe_q        <= pe_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = rx_data;
        valid_n = rx_valid;
        fe_n    = 1'b0;
        oe_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n  = perr_q;
        pe_n    = 1'b0;
`endif
        // A handshake this cycle frees the buffer for a frame ending now.
        if (rx_valid && rx_ready) begin
            valid_n = 1'b0;
        end

        unique case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_n   = HALF;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - 16'd1;
                end else if (!rx_s) begin
                    cnt_n   = FULL;
                    idx_n   = '0;
                    state_n = ST_DATA;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    cnt_n   = FULL;
                    idx_n   = idx + 4'd1;
                    if (idx == LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    perr_n  = uart_parity(8'(shreg)) ^ rx_s;
                    cnt_n   = FULL;
                    state_n = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - 16'd1;
                end else if (!rx_s) begin
                    fe_n    = 1'b1;
                    state_n = ST_BREAK;
`ifdef UART_RX_PARITY_EN
                end else if (perr_q) begin
                    pe_n    = 1'b1;
                    state_n = ST_IDLE;
`endif
                end else begin
                    if (valid_n) begin
                        oe_n = 1'b1;
                    end else begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                    end
                    state_n = ST_IDLE;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: random frames against a frame-level model.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int n_fe = 0, n_pe = 0, n_oe = 0, n_vcyc = 0;
    int exp_fe = 0, exp_pe = 0, exp_oe = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    // Inputs change just after posedge, so negedge sees the next edge's view.
    always @(negedge clk) begin
        if (frame_err)   n_fe++;
        if (parity_err)  n_pe++;
        if (overrun_err) n_oe++;
        if (rx_valid)    n_vcyc++;
        if (rx_valid && rx_ready) got.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves rx at the stop level; callers release a low stop themselves.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic bad_par);
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ bad_par;
        step(CPB);
`else
        if (bad_par) rx = 1'b1;
`endif
        rx = stop_bit;
        step(CPB);
    endtask

    task automatic settle(input string tag);
        step(3);
        check({tag, "_nbytes"}, got.size(), exp_q.size());
        while (got.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, got.pop_front(), exp_q.pop_front());
        got.delete();
        exp_q.delete();
        check({tag, "_fe"}, n_fe, exp_fe);
        check({tag, "_pe"}, n_pe, exp_pe);
        check({tag, "_oe"}, n_oe, exp_oe);
    endtask

    initial begin
        logic [7:0] d;
        logic       bad_stop, bad_p;
        int         v0;

        step(4);
        rst = 1'b0;
        step(1);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_data", rx_data, 8'h00);
        check("rst_errs", {frame_err, parity_err, overrun_err}, 3'b000);

        // Single byte, consumer always ready: valid lasts one cycle.
        rx_ready = 1'b1;
        step(5);
        v0 = n_vcyc;
        send_frame(8'h4D, 1'b1, 1'b0);
        exp_q.push_back(8'h4D);
        settle("b4d");
        check("b4d_vcyc", n_vcyc - v0, 1);

        // Random frames with occasional framing (and parity) faults.
        for (int k = 0; k < 24; k++) begin
            d = 8'($urandom);
            bad_stop = ($urandom_range(0, 5) == 0);
`ifdef UART_RX_PARITY_EN
            bad_p = ($urandom_range(0, 4) == 0);
`else
            bad_p = 1'b0;
`endif
            send_frame(d, !bad_stop, bad_p);
            if (bad_stop) begin
                exp_fe++;
                step($urandom_range(3, 30));
                rx = 1'b1;
            end else if (bad_p) begin
                exp_pe++;
            end else begin
                exp_q.push_back(d);
            end
            settle("rnd");
            step($urandom_range(0, 4));
        end

        // Back-to-back burst with one stop bit each.
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, 1'b0);
            exp_q.push_back(d);
        end
        settle("burst");

        // Overrun: consumer stalled across two back-to-back frames.
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        step(3);
        exp_oe++;
        check("ovr_oe", n_oe, exp_oe);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_data", rx_data, 8'h5A);
        rx_ready = 1'b1;
        exp_q.push_back(8'h5A);
        settle("ovr");

        // Short low glitch must not be taken as a start bit.
        v0 = n_vcyc;
        rx = 1'b0;
        step(6);
        rx = 1'b1;
        step(12 * CPB);
        check("glitch_vcyc", n_vcyc - v0, 0);
        settle("glitch");

        // Framing error, line held low, then a clean frame.
        send_frame(8'h33, 1'b0, 1'b0);
        step(40);
        exp_fe++;
        check("brk_valid", rx_valid, 1'b0);
        settle("brk");
        rx = 1'b1;
        step(4);
        send_frame(8'h0F, 1'b1, 1'b0);
        exp_q.push_back(8'h0F);
        settle("after_brk");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        exp_pe++;
        settle("par_bad");
        send_frame(8'h07, 1'b1, 1'b0);
        exp_q.push_back(8'h07);
        settle("par_ok");
`endif

        // Reset mid-frame while an old byte is held.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        step(3);
        check("hold_valid", rx_valid, 1'b1);
        d = 8'hC3;
        rx = 1'b0;
        step(CPB);
        rx = d[0];
        step(CPB);
        rx = d[1];
        step(CPB / 2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_valid", rx_valid, 1'b0);
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_errs", {frame_err, parity_err, overrun_err}, 3'b000);
        rx = 1'b1;
        step(12 * CPB);
        rx_ready = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0);
        exp_q.push_back(8'h81);
        settle("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
